// File: rtl/rv32im_pkg.sv
// rtl/rv32im_pkg.sv - shared constants, state encoding and sizing helper for the RV32M unit
package rv32im_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIXUP,
    SPECIAL,
    DONE
  } state_t;

  function automatic int cnt_width(input int xlen, input int bpc);
    return $clog2(xlen / bpc);
  endfunction

endpackage

// File: rtl/rv32im_muldiv_dec.sv
// rtl/rv32im_muldiv_dec.sv - funct3 decode into operation class and operand signedness
module rv32im_muldiv_dec
  import rv32im_pkg::*;
(
  input  logic [2:0] funct3,
  output logic       is_div,
  output logic       is_rem,
  output logic       want_high,
  output logic       a_signed,
  output logic       b_signed
);

  always_comb begin
    is_div    = funct3[2];
    is_rem    = funct3[2] & funct3[1];
    want_high = 1'b0;
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    case (funct3)
      F3_MULH: begin
        want_high = 1'b1;
        a_signed  = 1'b1;
        b_signed  = 1'b1;
      end
      F3_MULHSU: begin
        want_high = 1'b1;
        a_signed  = 1'b1;
      end
      F3_MULHU: want_high = 1'b1;
      F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32im_muldiv.sv
// rtl/rv32im_muldiv.sv - iterative shift-add multiplier / restoring divider for RV32M
module rv32im_muldiv
  import rv32im_pkg::*;
#(
  parameter int XLEN           = DEFAULT_XLEN,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = cnt_width(XLEN, BITS_PER_CYCLE);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   op_a, op_b;
  logic [2*XLEN-1:0] acc;
  logic is_div_q, is_rem_q, want_high_q, neg_q;
  logic d_is_div, d_is_rem, d_want_high, d_a_signed, d_b_signed;
  logic a_neg, b_neg, special, accept;

  logic [2*XLEN-1:0] mul_acc, prod_fix;
  logic [XLEN-1:0]   mul_b, div_rem, div_q, div_val, fix_result, spec_result;
  logic [XLEN:0]     trial;

  rv32im_muldiv_dec u_dec (
    .funct3    (funct3),
    .is_div    (d_is_div),
    .is_rem    (d_is_rem),
    .want_high (d_want_high),
    .a_signed  (d_a_signed),
    .b_signed  (d_b_signed)
  );

  assign a_neg   = d_a_signed & rs1_i[XLEN-1];
  assign b_neg   = d_b_signed & rs2_i[XLEN-1];
  assign special = d_is_div & ((rs2_i == '0) |
                   (d_b_signed & (rs1_i == MIN_NEG) & (rs2_i == '1)));
  assign accept  = start_i & ~kill_i & ((state == IDLE) | (state == DONE));

  // Multiplier consumed MSB-first so the product accumulates by left shifts;
  // the dividend shifts out of op_a while quotient bits shift in behind it.
  always_comb begin
    mul_acc = acc;
    mul_b   = op_b;
    div_rem = acc[XLEN-1:0];
    div_q   = op_a;
    trial   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      mul_acc = {mul_acc[2*XLEN-2:0], 1'b0} +
                (mul_b[XLEN-1] ? {{XLEN{1'b0}}, op_a} : '0);
      mul_b   = {mul_b[XLEN-2:0], 1'b0};
      trial   = {div_rem, div_q[XLEN-1]};
      div_q   = {div_q[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, op_b}) begin
        trial    = trial - {1'b0, op_b};
        div_q[0] = 1'b1;
      end
      div_rem = trial[XLEN-1:0];
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    div_val  = is_rem_q ? acc[XLEN-1:0] : op_a;
    if (is_div_q)
      fix_result = neg_q ? -div_val : div_val;
    else
      fix_result = want_high_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    // Special operands were captured raw: op_b == 0 marks divide-by-zero.
    if (op_b == '0)
      spec_result = is_rem_q ? op_a : '1;
    else
      spec_result = is_rem_q ? '0 : op_a;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_next = special ? SPECIAL : ITER;
      end
      ITER: begin
        busy_o = 1'b1;
        if (kill_i)         state_next = IDLE;
        else if (cnt == '0) state_next = FIXUP;
      end
      FIXUP, SPECIAL: begin
        busy_o     = 1'b1;
        state_next = kill_i ? IDLE : DONE;
      end
      DONE: begin
        ready_o    = 1'b1;
        done_o     = 1'b1;
        state_next = accept ? (special ? SPECIAL : ITER) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      acc         <= '0;
      is_div_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      want_high_q <= 1'b0;
      neg_q       <= 1'b0;
      result_o    <= '0;
    end else if (accept) begin
      cnt         <= CW'(N - 1);
      acc         <= '0;
      is_div_q    <= d_is_div;
      is_rem_q    <= d_is_rem;
      want_high_q <= d_want_high;
      if (special) begin
        op_a  <= rs1_i;
        op_b  <= rs2_i;
        neg_q <= 1'b0;
      end else begin
        op_a  <= a_neg ? -rs1_i : rs1_i;
        op_b  <= b_neg ? -rs2_i : rs2_i;
        neg_q <= d_is_rem ? a_neg : (a_neg ^ b_neg);
      end
    end else begin
      case (state)
        ITER: begin
          cnt  <= cnt - 1'b1;
          acc  <= is_div_q ? {{XLEN{1'b0}}, div_rem} : mul_acc;
          op_a <= is_div_q ? div_q : op_a;
          op_b <= is_div_q ? op_b : mul_b;
        end
        FIXUP:   if (!kill_i) result_o <= fix_result;
        SPECIAL: if (!kill_i) result_o <= spec_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_muldiv.sv
// tb/tb_rv32im_muldiv.sv - self-checking bench for rv32im_muldiv at three width/rate points
module tb_rv32im_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  int          sel;

  logic        ready_v[3];
  logic        busy_v[3];
  logic        done_v[3];
  logic [31:0] res_v[3];
  logic [31:0] res0, res1;
  logic [15:0] res16;

  int tests = 0;
  int fails = 0;

  assign res_v[0] = res0;
  assign res_v[1] = res1;
  assign res_v[2] = {16'h0, res16};

  rv32im_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel == 0), .funct3(funct3),
    .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill),
    .ready_o(ready_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .result_o(res0));

  rv32im_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel == 1), .funct3(funct3),
    .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill),
    .ready_o(ready_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .result_o(res1));

  rv32im_muldiv #(.XLEN(16), .BITS_PER_CYCLE(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel == 2), .funct3(funct3),
    .rs1_i(rs1[15:0]), .rs2_i(rs2[15:0]), .kill_i(kill),
    .ready_o(ready_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]), .result_o(res16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int xlv(input int d);
    return (d == 2) ? 16 : 32;
  endfunction

  function automatic int nv(input int d);
    case (d)
      0:       return 32;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] maskv(input int d);
    longint m;
    m = (longint'(1) << xlv(d)) - 1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] minv(input int d);
    longint m;
    m = longint'(1) << (xlv(d) - 1);
    return m[31:0];
  endfunction

  // Maps a 32-bit test vector onto a narrower width keeping its sign/extreme character.
  function automatic logic [31:0] adapt(input logic [31:0] v, input int d);
    return v[31] ? ((v & maskv(d)) | minv(d)) : (v & maskv(d));
  endfunction

  // Reference arithmetic on wide integers, straight from the RV32M definitions.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input int xl);
    longint mask, ua, ub, sa, sb, r;
    longint unsigned pu;
    mask = (longint'(1) << xl) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[xl-1] ? ua - (longint'(1) << xl) : ua;
    sb = ub[xl-1] ? ub - (longint'(1) << xl) : ub;
    case (f3)
      3'b000: r = sa * sb;
      3'b001: r = (sa * sb) >>> xl;
      3'b010: r = (sa * ub) >>> xl;
      3'b011: begin
        pu = ua * ub;
        r  = longint'(pu >> xl);
      end
      3'b100: r = (ub == 0) ? -1 :
                  ((sa == -(longint'(1) << (xl - 1)) && sb == -1) ? sa : sa / sb);
      3'b101: r = (ub == 0) ? -1 : ua / ub;
      3'b110: r = (ub == 0) ? sa :
                  ((sa == -(longint'(1) << (xl - 1)) && sb == -1) ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation on DUT d and returns at the negedge of its done cycle.
  task automatic run_op(input int d, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
    int k;
    bit rdy_bad;
    bit spec;
    spec = f3[2] && (b == 0 || (!f3[0] && a == minv(d) && b == maskv(d)));
    check({tag, "/ready_at_start"}, 32'(ready_v[d]), 32'd1);
    sel = d; funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
    k = 1;
    rdy_bad = 1'b0;
    while (!done_v[d] && k < 200) begin
      if (ready_v[d]) rdy_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check({tag, "/latency"}, 32'(k), 32'(spec ? 2 : nv(d) + 2));
    check({tag, "/ready_low_while_busy"}, 32'(rdy_bad), 32'd0);
    check({tag, "/result"}, res_v[d], exp);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dir[14];

  initial begin
    logic [31:0] a, b, e;
    logic [2:0]  f;
    bit saw;

    dir = '{
      '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB},
      '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000},
      '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},
      '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF},
      '{3'b010, 32'hFFFFFFFF,   32'd0,        32'd0},
      '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},
      '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},
      '{3'b101, 32'd100,        32'd7,        32'd14},
      '{3'b111, 32'd100,        32'd7,        32'd2},
      '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF},
      '{3'b111, 32'd5,          32'd0,        32'd5},
      '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000},
      '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0},
      '{3'b110, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9}
    };

    rst = 1'b1; start = 1'b0; kill = 1'b0; sel = 0;
    funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d/ready", d), 32'(ready_v[d]), 32'd1);
      check($sformatf("reset%0d/busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset%0d/done", d), 32'(done_v[d]), 32'd0);
      check($sformatf("reset%0d/result", d), res_v[d], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 14; i++) begin
        a = adapt(dir[i].a, d);
        b = adapt(dir[i].b, d);
        e = (xlv(d) == 32) ? dir[i].e : ref_op(dir[i].f, a, b, xlv(d));
        run_op(d, dir[i].f, a, b, e, $sformatf("dir%0d_%0d", d, i));
        @(negedge clk);
      end
    end

    // Back-to-back: second start lands in the DONE cycle of the first.
    run_op(0, 3'b000, 32'd3, 32'd5, 32'd15, "b2b_first");
    run_op(0, 3'b101, 32'd1000, 32'd3, 32'd333, "b2b_second");
    @(negedge clk);

    // Kill mid-iteration: unit returns to IDLE, keeps the old result.
    sel = 0; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill/busy", 32'(busy_v[0]), 32'd0);
    check("kill/ready", 32'(ready_v[0]), 32'd1);
    check("kill/done", 32'(done_v[0]), 32'd0);
    check("kill/result", res_v[0], 32'd333);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0]) saw = 1'b1;
    end
    check("kill/no_done", 32'(saw), 32'd0);

    // Kill with start in DONE: the new request is dropped.
    run_op(0, 3'b000, 32'd6, 32'd7, 32'd42, "killdone_op");
    funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("killdone/busy", 32'(busy_v[0]), 32'd0);
    check("killdone/ready", 32'(ready_v[0]), 32'd1);

    // Kill with start in IDLE: ignored.
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("killidle/busy", 32'(busy_v[0]), 32'd0);
    check("killidle/result", res_v[0], 32'd42);

    // Randomised operations against the reference model, mixing idle gaps and back-to-back.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 30; i++) begin
        f = 3'($urandom);
        case ($urandom_range(0, 5))
          0: a = 0;
          1: a = maskv(d);
          2: a = minv(d);
          3: a = $urandom_range(0, 9);
          default: a = $urandom & maskv(d);
        endcase
        case ($urandom_range(0, 5))
          0: b = 0;
          1: b = maskv(d);
          2: b = minv(d);
          3: b = $urandom_range(0, 9);
          default: b = $urandom & maskv(d);
        endcase
        run_op(d, f, a, b, ref_op(f, a, b, xlv(d)), $sformatf("rnd%0d_%0d_f%0d", d, i, f));
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);
    end

    // Reset mid-operation.
    sel = 0; funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset/ready", 32'(ready_v[0]), 32'd1);
    check("midreset/busy", 32'(busy_v[0]), 32'd0);
    check("midreset/done", 32'(done_v[0]), 32'd0);
    check("midreset/result", res_v[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
